mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single backing memory among `N_REQ` requesters (typically instruction and data caches) over the `MemBus` request/response protocol. Sits between the caches' memory-side ports and `Mem`. It owns one outstanding transaction at a time, routes the read response back to the requester that issued it, and flags protocol violations from the memory side.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2–8).
- `ADDR_WIDTH`, 6: line address width.
- `DATA_WIDTH`, 32: line data width.

Ports. Requester arrays are packed, with requester i at slice i.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  N_REQ: request pending per requester.
- `req_write`  in  N_REQ: 1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_WIDTH: request address.
- `req_data`  in  N_REQ*DATA_WIDTH: write data.
- `req_ready`  out  N_REQ: one-hot accept pulse.
- `rsp_valid`  out  N_REQ: one-hot read-response pulse.
- `rsp_data`  out  DATA_WIDTH: read data, shared across requesters.
- `mem_req_valid`  out  1, `mem_req_write`  out  1, `mem_req_addr`  out  ADDR_WIDTH, `mem_req_data`  out  DATA_WIDTH: request to memory.
- `mem_req_ready`  in  1: memory accepts the request.
- `mem_rsp_valid`  in  1, `mem_rsp_data`  in  DATA_WIDTH: memory read response.
- `err`  out  1: sticky protocol-error flag.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT_RSP`.
- **IDLE**
  - Winner = first asserted `req_valid[i]`, searching from `ptr` upward with wrap-around.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - At the clock edge: latch write/addr/data and owner index; set `ptr` to (winner+1) mod N_REQ; go to ISSUE.
  - With no `req_valid`, stay in IDLE and leave `ptr` unchanged.
- **ISSUE**
  - `mem_req_*` are driven from the latched registers and stay stable while `mem_req_valid` is high.
  - On `mem_req_ready`: a write goes to IDLE (no response); a read goes to WAIT_RSP.
- **WAIT_RSP**
  - On `mem_rsp_valid`: register `mem_rsp_data` into `rsp_data` and pulse `rsp_valid[owner]` for exactly one cycle.
  - Then go to IDLE.
- **Error cases:** `err` sets on either condition below and clears only on reset; the FSM ignores the offending event.
  - `mem_rsp_valid` while not in WAIT_RSP.
  - `mem_req_ready` while not in ISSUE.
- Requesters must hold `req_*` stable until `req_ready`. The arbiter does not check this.

## Timing
- **Reset values:** state IDLE, `ptr` 0, `err` 0. All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, all `mem_req_*`.
- **Reset mid-transaction:** the transaction is abandoned. No `rsp_valid` is generated for it.
- **Request path:** request seen at cycle 0 (IDLE, `req_ready` high). `mem_req_valid` rises at cycle 1.
  - Memory accepting immediately gives a 2-cycle request-to-accept turnaround.
- **Read path:** `mem_rsp_valid` at cycle k gives `rsp_valid[owner]` at cycle k+1. The FSM is in IDLE at k+1, so the next grant can occur in cycle k+1.
- **Write path:** `mem_req_ready` at cycle k returns the FSM to IDLE at k+1. The next grant can occur at k+1.
- **New requests while busy:** requests arriving in ISSUE or WAIT_RSP see `req_ready` = 0 and wait.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,N_REQ−1,0. The worst-case wait is N_REQ−1 transactions.
- **Outputs:** `req_ready` is combinational from state, `req_valid` and `ptr`. All other outputs are registered.

## Structure
- Shared package `mem_pkg` holds:
  - `ADDR_WIDTH` and `DATA_WIDTH` defaults;
  - the `mem_req_t` struct (write, addr, data);
  - the `arb_state_t` enum (IDLE, ISSUE, WAIT_RSP).
- One sub-module, `rr_picker`:
  - inputs: `req_valid`, `ptr`;
  - outputs: `grant_valid` and the `grant_idx` index;
  - purely combinational;
  - unit-testable alone.
- Top-level integration: instantiated between the cache-side `MemBus` instances and the `Mem` bus.

## Test plan
- **Reset:** assert `rst_n`=0 mid-read (state WAIT_RSP). Required: all outputs 0, state IDLE, and no `rsp_valid` after release even if `mem_rsp_valid` arrives, which sets `err`=1.
- **Single read:** req 1 read at addr 0x2A; memory ready at once and responds 3 cycles later with 0xDEADBEEF. Required: `req_ready`=0b10 at cycle 0, `mem_req_addr`=0x2A at cycle 1, `rsp_valid`=0b10 with `rsp_data`=0xDEADBEEF one cycle after `mem_rsp_valid`.
- **Write, no response:** req 0 writes 0x12345678 to 0x05; `mem_req_ready` delayed 4 cycles. Required: `mem_req_*` stable for all 4 cycles, return to IDLE, no `rsp_valid`, `err`=0.
- **Round-robin:** both requesters continuously valid for 6 reads. Required: grant order 0,1,0,1,0,1.
- **Simultaneous events:** req 0 asserts in the same cycle req 1's response returns. Required: `rsp_valid`=0b10 next cycle, and req 0 granted in that same cycle.
- **Protocol error:** `mem_rsp_valid` pulsed while IDLE. Required: `err` goes to 1 and stays 1, no `rsp_valid`, and the next transaction completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   ADDR_WIDTH / DATA_WIDTH : default line address / data widths
//   mem_req_t               : one memory request (write flag, address, data)
//   arb_state_t             : arbiter FSM state encoding
package mem_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_valid   in  : pending request per requester
//   ptr         in  : highest-priority requester index this round
//   grant_valid out : at least one request is pending
//   grant_idx   out : first pending requester at or after ptr (wrapping)
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  int idx;

  // Scan offsets from farthest to nearest so the closest pending requester
  // to ptr is the last assignment and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory among N_REQ requesters.
// One transaction outstanding at a time; read data is routed back to the
// requester that issued it. err is a sticky flag for memory-side protocol
// violations (unexpected mem_req_ready / mem_rsp_valid).
//   req_valid/req_write/req_addr/req_data in  : packed per-requester requests
//   req_ready  out : one-hot accept (combinational)
//   rsp_valid  out : one-hot read-response pulse; rsp_data shared
//   mem_req_*  out : registered request to memory; mem_req_ready in
//   mem_rsp_valid/mem_rsp_data in : memory read response
//   err        out : sticky protocol error, cleared only by reset
//
// state    | meaning
// IDLE     | no transaction; grant the round-robin winner combinationally
// ISSUE    | request presented to memory, waiting for mem_req_ready
// WAIT_RSP | read accepted by memory, waiting for mem_rsp_valid
module mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_write,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [DATA_WIDTH-1:0]       mem_req_data,
  input  logic                        mem_req_ready,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]       mem_rsp_data,
  output logic                        err
);
  import mem_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_valid   (req_valid),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Gated by rst_n so no accept is signalled while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_valid) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    wr_d            = wr_q;
    addr_d          = addr_q;
    data_d          = data_q;
    mem_req_valid_d = mem_req_valid_q;
    rsp_valid_d     = '0;
    rsp_data_d      = rsp_data_q;
    err_d           = err_q;

    if (mem_rsp_valid && state_q != WAIT_RSP) err_d = 1'b1;
    if (mem_req_ready && state_q != ISSUE)    err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          wr_d            = req_write[grant_idx];
          addr_d          = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d          = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          owner_d         = grant_idx;
          ptr_d           = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = wr_q ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_data_d           = mem_rsp_data;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_q           <= err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = wr_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, a transaction-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_req_valid, mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_req_ready, mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            err;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  mem_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: the arbiter is free, has a request outstanding to
  // memory, or has an accepted read awaiting data. last_grant remembers the
  // previously served requester; the next search starts just after it.
  localparam int FREE = 0, ISSUING = 1, AWAITING = 2;
  int            phase = FREE;
  int            last_grant = N - 1;
  int            owner = 0;
  logic          m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  m_rsp_vec = '0;
  logic [DW-1:0] m_rsp_data = '0;
  logic          m_err = 0;
  int            g_now;
  logic [N-1:0]  exp_ready;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always_comb g_now = pick(req_valid, last_grant);

  always_comb begin
    exp_ready = '0;
    if (rst_n === 1'b1 && phase == FREE && g_now >= 0) exp_ready[g_now] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= FREE; last_grant <= N - 1; owner <= 0;
      m_wr <= 0; m_addr <= '0; m_data <= '0;
      m_rsp_vec <= '0; m_rsp_data <= '0; m_err <= 0;
    end else begin
      m_rsp_vec <= '0;
      if (mem_rsp_valid && phase != AWAITING) m_err <= 1;
      if (mem_req_ready && phase != ISSUING)  m_err <= 1;
      if (phase == FREE && g_now >= 0) begin
        m_wr       <= req_write[g_now];
        m_addr     <= req_addr[g_now*AW +: AW];
        m_data     <= req_data[g_now*DW +: DW];
        owner      <= g_now;
        last_grant <= g_now;
        phase      <= ISSUING;
      end else if (phase == ISSUING && mem_req_ready) begin
        phase <= m_wr ? FREE : AWAITING;
      end else if (phase == AWAITING && mem_rsp_valid) begin
        m_rsp_vec[owner] <= 1'b1;
        m_rsp_data       <= mem_rsp_data;
        phase            <= FREE;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_rsp_valid", rsp_valid, m_rsp_vec);
      chk("m_rsp_data", rsp_data, m_rsp_data);
      chk("m_mem_valid", mem_req_valid, (phase == ISSUING));
      chk("m_mem_write", mem_req_write, m_wr);
      chk("m_mem_addr", mem_req_addr, m_addr);
      chk("m_mem_data", mem_req_data, m_data);
      chk("m_err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
    req_valid[idx] = 1'b1; req_write[idx] = 1'b0; req_addr[idx*AW +: AW] = a;
    @(negedge clk); chk("rd_grant", req_ready, 64'(1) << idx);
    tick(); req_valid[idx] = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); chk("rd_mem_valid", mem_req_valid, 1); chk("rd_mem_addr", mem_req_addr, a);
    tick(); mem_req_ready = 1'b0;
    repeat (lat - 1) tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = d;
    tick(); mem_rsp_valid = 1'b0;
    @(negedge clk); chk("rd_rsp_valid", rsp_valid, 64'(1) << idx); chk("rd_rsp_data", rsp_data, d);
    tick();
    @(negedge clk); chk("rd_rsp_pulse", rsp_valid, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[6];
    int grants, rsps;
    bit pend;
    logic [AW-1:0] addr_hold;

    rst_n = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    #2 rst_n = 1'b0;
    started = 1;
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0); chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_valid", mem_req_valid, 0); chk("rst_err", err, 0);
    tick(); rst_n = 1'b1; tick();

    // single read, 3-cycle memory latency
    do_read(1, 6'h2A, 32'hDEADBEEF, 3);
    chk("rd_err", err, 0);

    // round robin: both continuously valid for 6 reads
    req_valid = 2'b11; req_write = 2'b00; req_addr = {6'h30, 6'h20};
    pend = 0; grants = 0; rsps = 0; addr_hold = '0;
    for (int cyc = 0; cyc < 200 && rsps < 6; cyc++) begin
      mem_req_ready = mem_req_valid;
      mem_rsp_valid = pend;
      mem_rsp_data  = 32'hA000_0000 | DW'(addr_hold);
      pend = 0;
      if (grants >= 6) req_valid = '0;
      @(negedge clk);
      if (req_ready != 0 && grants < 6) begin
        order[grants] = req_ready[1] ? 1 : 0;
        grants++;
      end
      if (rsp_valid != 0) rsps++;
      if (mem_req_valid && mem_req_ready && !mem_req_write) begin
        pend = 1; addr_hold = mem_req_addr;
      end
      tick();
    end
    mem_req_ready = 0; mem_rsp_valid = 0; req_valid = '0;
    chk("rr_rsp_count", rsps, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    chk("rr_err", err, 0);
    tick();

    // write with memory ready delayed 4 cycles
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 6'h05; req_data[0 +: DW] = 32'h12345678;
    @(negedge clk); chk("wr_grant", req_ready, 2'b01);
    tick(); req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_hold_valid", mem_req_valid, 1); chk("wr_hold_write", mem_req_write, 1);
      chk("wr_hold_addr", mem_req_addr, 6'h05); chk("wr_hold_data", mem_req_data, 32'h12345678);
      tick();
    end
    mem_req_ready = 1;
    tick(); mem_req_ready = 0;
    @(negedge clk);
    chk("wr_done_valid", mem_req_valid, 0); chk("wr_no_rsp", rsp_valid, 0); chk("wr_err", err, 0);
    tick();
    @(negedge clk); chk("wr_no_rsp2", rsp_valid, 0);
    tick();

    // simultaneous: req0 arrives while req1's response returns
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 6'h11;
    @(negedge clk); chk("sim_grant1", req_ready, 2'b10);
    tick(); req_valid = '0; mem_req_ready = 1;
    tick(); mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h0BADCAFE;
    req_valid = 2'b01; req_addr[0 +: AW] = 6'h03;
    @(negedge clk); chk("sim_busy", req_ready, 2'b00);
    tick(); mem_rsp_valid = 0;
    @(negedge clk);
    chk("sim_rsp", rsp_valid, 2'b10); chk("sim_rsp_data", rsp_data, 32'h0BADCAFE);
    chk("sim_grant0", req_ready, 2'b01);
    tick(); req_valid = '0; mem_req_ready = 1;
    @(negedge clk); chk("sim_addr0", mem_req_addr, 6'h03);
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h55AA55AA;
    tick(); mem_rsp_valid = 0;
    @(negedge clk); chk("sim_rsp0", rsp_valid, 2'b01); chk("sim_rsp0_data", rsp_data, 32'h55AA55AA);
    tick();

    // protocol error: response while idle
    mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF0000;
    tick(); mem_rsp_valid = 0;
    @(negedge clk); chk("pe_err", err, 1); chk("pe_no_rsp", rsp_valid, 0);
    tick();
    do_read(0, 6'h09, 32'hCAFEF00D, 1);
    chk("pe_err_sticky", err, 1);

    // reset in the middle of a read
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 6'h15;
    @(negedge clk); chk("mr_grant", req_ready, 2'b10);
    tick(); req_valid = '0; mem_req_ready = 1;
    tick(); mem_req_ready = 0;
    @(negedge clk); chk("mr_waiting", mem_req_valid, 0);
    tick(); rst_n = 0; req_valid = 2'b01;
    @(negedge clk);
    chk("mr_req_ready", req_ready, 0); chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_data", rsp_data, 0); chk("mr_mem_valid", mem_req_valid, 0);
    chk("mr_mem_addr", mem_req_addr, 0); chk("mr_mem_data", mem_req_data, 0);
    chk("mr_mem_write", mem_req_write, 0); chk("mr_err", err, 0);
    tick(); req_valid = '0; rst_n = 1;
    tick(); mem_rsp_valid = 1; mem_rsp_data = 32'h00000BAD;
    tick(); mem_rsp_valid = 0;
    @(negedge clk); chk("mr_no_rsp", rsp_valid, 0); chk("mr_err_set", err, 1);
    tick();

    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
